// File: rtl/pong_ball_ctrl_v2_if.sv
// Ball controller signal bundle: game-state/video inputs and ball/score outputs.
interface pong_ball_ctrl_v2_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5
);
  logic           i_Game_Active;
  logic [X_W-1:0] i_Col_Count_Div;
  logic [Y_W-1:0] i_Row_Count_Div;
  logic [Y_W-1:0] i_Paddle_Y_P1;
  logic [Y_W-1:0] i_Paddle_Y_P2;
  logic           o_Draw_Ball;
  logic [X_W-1:0] o_Ball_X;
  logic [Y_W-1:0] o_Ball_Y;
  logic           o_P1_Miss;
  logic           o_P2_Miss;
  logic [3:0]     o_Speed_Level;

  modport master (
    output i_Game_Active, i_Col_Count_Div, i_Row_Count_Div, i_Paddle_Y_P1, i_Paddle_Y_P2,
    input  o_Draw_Ball, o_Ball_X, o_Ball_Y, o_P1_Miss, o_P2_Miss, o_Speed_Level
  );

  modport slave (
    input  i_Game_Active, i_Col_Count_Div, i_Row_Count_Div, i_Paddle_Y_P1, i_Paddle_Y_P2,
    output o_Draw_Ball, o_Ball_X, o_Ball_Y, o_P1_Miss, o_P2_Miss, o_Speed_Level
  );
endinterface

// File: rtl/pong_ball_ctrl_v2.sv
// Pong ball controller: serve delay, wall bounce, paddle reflect against both
// players, miss pulses and a hit-driven speed-up of the step period.
module pong_ball_ctrl_v2 #(
  parameter int c_GAME_WIDTH     = 40,
  parameter int c_GAME_HEIGHT    = 30,
  parameter int c_PADDLE_HEIGHT  = 6,
  parameter int c_BALL_SPEED     = 1250000,
  parameter int c_BALL_SPEED_MIN = 312500,
  parameter int c_SPEED_STEP     = 156250,
  parameter int c_HITS_PER_LEVEL = 4,
  parameter int c_SERVE_DELAY    = 20
) (
  input logic                i_Clk,
  input logic                i_Rst,
  pong_ball_ctrl_v2_if.slave bus
);
  localparam int X_W = $clog2(c_GAME_WIDTH);
  localparam int Y_W = $clog2(c_GAME_HEIGHT);
  localparam int C_W = $clog2(c_BALL_SPEED + 1);
  localparam int S_W = $clog2(c_SERVE_DELAY + 1);
  localparam int H_W = $clog2(c_HITS_PER_LEVEL + 1);

  localparam logic [X_W-1:0] X_MID    = X_W'(c_GAME_WIDTH / 2);
  localparam logic [Y_W-1:0] Y_MID    = Y_W'(c_GAME_HEIGHT / 2);
  localparam logic [X_W-1:0] X_LAST   = X_W'(c_GAME_WIDTH - 1);
  localparam logic [X_W-1:0] X_P2_HIT = X_W'(c_GAME_WIDTH - 2);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(c_GAME_HEIGHT - 1);
  localparam logic [C_W-1:0] P_INIT   = C_W'(c_BALL_SPEED);
  localparam logic [C_W-1:0] P_MIN    = C_W'(c_BALL_SPEED_MIN);
  localparam logic [C_W-1:0] P_STEP   = C_W'(c_SPEED_STEP);
  // one bit wider so min+step can never wrap in the floor comparison
  localparam logic [C_W:0]   P_FLOOR  = (C_W+1)'(c_BALL_SPEED_MIN + c_SPEED_STEP);
  localparam logic [Y_W:0]   PAD_SPAN = (Y_W+1)'(c_PADDLE_HEIGHT - 1);
  localparam logic [S_W-1:0] SRV_LAST = S_W'(c_SERVE_DELAY - 1);
  localparam logic [H_W-1:0] HIT_LAST = H_W'(c_HITS_PER_LEVEL - 1);

  typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} state_t;

  state_t         state;
  logic [X_W-1:0] ball_x;
  logic [Y_W-1:0] ball_y;
  logic           dir_x_pos, dir_y_pos;
  logic [C_W-1:0] step_cnt, period;
  logic [S_W-1:0] serve_cnt;
  logic [H_W-1:0] hit_cnt;
  logic [3:0]     level;
  logic           p1_miss, p2_miss, draw;

  logic           tick, p1_in, p2_in;
  logic [C_W-1:0] period_dec;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           dx_nxt, dy_nxt, paddle_hit, miss_p1, miss_p2;

  assign tick = (step_cnt == period - C_W'(1));

  // paddle spans compared at Y_W+1 bits so a paddle near the bottom cannot wrap
  assign p1_in = ({1'b0, ball_y} >= {1'b0, bus.i_Paddle_Y_P1}) &&
                 ({1'b0, ball_y} <= {1'b0, bus.i_Paddle_Y_P1} + PAD_SPAN);
  assign p2_in = ({1'b0, ball_y} >= {1'b0, bus.i_Paddle_Y_P2}) &&
                 ({1'b0, ball_y} <= {1'b0, bus.i_Paddle_Y_P2} + PAD_SPAN);

  assign period_dec = ({1'b0, period} >= P_FLOOR) ? period - P_STEP : P_MIN;

  // next ball position/direction for a MOVE tick; paddle test uses pre-update Y
  always_comb begin
    y_nxt      = ball_y;
    dy_nxt     = dir_y_pos;
    x_nxt      = ball_x;
    dx_nxt     = dir_x_pos;
    paddle_hit = 1'b0;
    miss_p1    = 1'b0;
    miss_p2    = 1'b0;
    if (dir_y_pos && ball_y == Y_LAST) begin
      dy_nxt = 1'b0;
      y_nxt  = ball_y - Y_W'(1);
    end else if (!dir_y_pos && ball_y == '0) begin
      dy_nxt = 1'b1;
      y_nxt  = Y_W'(1);
    end else if (dir_y_pos) begin
      y_nxt  = ball_y + Y_W'(1);
    end else begin
      y_nxt  = ball_y - Y_W'(1);
    end
    if (dir_x_pos && ball_x == X_P2_HIT) begin
      if (p2_in) begin
        dx_nxt     = 1'b0;
        x_nxt      = ball_x - X_W'(1);
        paddle_hit = 1'b1;
      end else begin
        x_nxt   = X_LAST;
        miss_p2 = 1'b1;
      end
    end else if (!dir_x_pos && ball_x == X_W'(1)) begin
      if (p1_in) begin
        dx_nxt     = 1'b1;
        x_nxt      = ball_x + X_W'(1);
        paddle_hit = 1'b1;
      end else begin
        x_nxt   = '0;
        miss_p1 = 1'b1;
      end
    end else if (dir_x_pos) begin
      x_nxt = ball_x + X_W'(1);
    end else begin
      x_nxt = ball_x - X_W'(1);
    end
  end

  // game FSM: reset and game-inactive both fully restore the serve-ready state
  always_ff @(posedge i_Clk) begin
    if (i_Rst || !bus.i_Game_Active) begin
      state     <= IDLE;
      ball_x    <= X_MID;
      ball_y    <= Y_MID;
      dir_x_pos <= 1'b1;
      dir_y_pos <= 1'b1;
      step_cnt  <= '0;
      period    <= P_INIT;
      serve_cnt <= '0;
      hit_cnt   <= '0;
      level     <= '0;
      p1_miss   <= 1'b0;
      p2_miss   <= 1'b0;
    end else begin
      p1_miss <= 1'b0;
      p2_miss <= 1'b0;
      case (state)
        IDLE: begin
          step_cnt  <= '0;
          serve_cnt <= '0;
          state     <= SERVE;
        end
        SERVE: begin
          if (tick) begin
            step_cnt <= '0;
            if (serve_cnt == SRV_LAST) begin
              serve_cnt <= '0;
              state     <= MOVE;
            end else begin
              serve_cnt <= serve_cnt + S_W'(1);
            end
          end else begin
            step_cnt <= step_cnt + C_W'(1);
          end
        end
        MOVE: begin
          if (tick) begin
            step_cnt  <= '0;
            ball_x    <= x_nxt;
            ball_y    <= y_nxt;
            dir_x_pos <= dx_nxt;
            dir_y_pos <= dy_nxt;
            if (paddle_hit) begin
              if (hit_cnt == HIT_LAST) begin
                hit_cnt <= '0;
                period  <= period_dec;
                if (level != 4'hF) level <= level + 4'd1;
              end else begin
                hit_cnt <= hit_cnt + H_W'(1);
              end
            end
            if (miss_p1 || miss_p2) begin
              p1_miss <= miss_p1;
              p2_miss <= miss_p2;
              state   <= SCORED;
            end
          end else begin
            step_cnt <= step_cnt + C_W'(1);
          end
        end
        SCORED: begin
          // next serve heads toward whoever just missed
          ball_x    <= X_MID;
          ball_y    <= Y_MID;
          dir_x_pos <= p2_miss;
          dir_y_pos <= 1'b1;
          step_cnt  <= '0;
          serve_cnt <= '0;
          period    <= P_INIT;
          hit_cnt   <= '0;
          level     <= '0;
          state     <= SERVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ball pixel match, one clock behind the video counters
  always_ff @(posedge i_Clk) begin
    if (i_Rst) draw <= 1'b0;
    else       draw <= (bus.i_Col_Count_Div == ball_x) && (bus.i_Row_Count_Div == ball_y);
  end

  assign bus.o_Draw_Ball   = draw;
  assign bus.o_Ball_X      = ball_x;
  assign bus.o_Ball_Y      = ball_y;
  assign bus.o_P1_Miss     = p1_miss;
  assign bus.o_P2_Miss     = p2_miss;
  assign bus.o_Speed_Level = level;
endmodule

// File: tb/tb_pong_ball_ctrl_v2.sv
// Bench for pong_ball_ctrl_v2 on a small 8x6 field with a fast step period.
module tb_pong_ball_ctrl_v2;
  localparam int W = 8, H = 6, PH = 3, BS = 4, SMIN = 2, SSTEP = 1, HPL = 1, SD = 2;
  localparam int XW = $clog2(W), YW = $clog2(H);
  localparam int FIRST_DT = 1 + SD * BS + BS;  // IDLE->SERVE, serve ticks, first move tick

  typedef struct {int dt; int x; int y; int lvl; int p2m;} exp_t;

  logic i_Clk = 1'b0;
  logic i_Rst;
  exp_t sb[$];
  int   checks = 0, passed = 0;
  bit   track_p1 = 0;

  always #5 i_Clk = ~i_Clk;

  pong_ball_ctrl_v2_if #(.X_W(XW), .Y_W(YW)) bus();

  pong_ball_ctrl_v2 #(
    .c_GAME_WIDTH(W), .c_GAME_HEIGHT(H), .c_PADDLE_HEIGHT(PH), .c_BALL_SPEED(BS),
    .c_BALL_SPEED_MIN(SMIN), .c_SPEED_STEP(SSTEP), .c_HITS_PER_LEVEL(HPL), .c_SERVE_DELAY(SD)
  ) dut (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus));

  // advance one clock, sample point is 1 time unit after the edge
  task automatic cyc();
    int yb;
    @(posedge i_Clk); #1;
    if (track_p1) begin
      yb = int'(bus.o_Ball_Y);
      bus.i_Paddle_Y_P1 = YW'((yb > H - PH) ? H - PH : yb);
    end
  endtask

  task automatic test_reset();
    int bad;
    i_Rst = 1; bus.i_Game_Active = 0; bus.i_Col_Count_Div = '0; bus.i_Row_Count_Div = '0;
    bus.i_Paddle_Y_P1 = '0; bus.i_Paddle_Y_P2 = '0;
    repeat (3) cyc();
    checks++;
    if (int'(bus.o_Ball_X) == 4 && int'(bus.o_Ball_Y) == 3) passed++;
    else $display("FAIL reset_pos got (%0d,%0d) want (4,3)", bus.o_Ball_X, bus.o_Ball_Y);
    checks++;
    if (bus.o_Speed_Level === 4'd0) passed++;
    else $display("FAIL reset_level got %0d want 0", bus.o_Speed_Level);
    checks++;
    if (bus.o_P1_Miss === 1'b0 && bus.o_P2_Miss === 1'b0) passed++;
    else $display("FAIL reset_miss got %b%b want 00", bus.o_P1_Miss, bus.o_P2_Miss);
    checks++;
    if (bus.o_Draw_Ball === 1'b0) passed++;
    else $display("FAIL reset_draw got %b want 0", bus.o_Draw_Ball);
    i_Rst = 0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      cyc();
      if (int'(bus.o_Ball_X) != 4 || int'(bus.o_Ball_Y) != 3 || bus.o_P1_Miss !== 1'b0 ||
          bus.o_P2_Miss !== 1'b0 || bus.o_Speed_Level !== 4'd0) bad++;
    end
    checks++;
    if (bad == 0) passed++;
    else $display("FAIL idle_hold got %0d bad cycles want 0", bad);
    bus.i_Col_Count_Div = XW'(4); bus.i_Row_Count_Div = YW'(3);
    cyc();
    checks++;
    if (bus.o_Draw_Ball === 1'b1) passed++;
    else $display("FAIL draw_hit got %b want 1", bus.o_Draw_Ball);
    bus.i_Col_Count_Div = XW'(5);
    cyc();
    checks++;
    if (bus.o_Draw_Ball === 1'b0) passed++;
    else $display("FAIL draw_off got %b want 0", bus.o_Draw_Ball);
    bus.i_Col_Count_Div = '0; bus.i_Row_Count_Div = '0;
  endtask

  task automatic test_serve_miss();
    int dt, lx, ly, n1, n2;
    exp_t e;
    bus.i_Paddle_Y_P1 = '0; bus.i_Paddle_Y_P2 = '0;
    sb.delete();
    sb.push_back('{FIRST_DT, 5, 4, 0, 0});
    sb.push_back('{BS, 6, 5, 0, 0});
    sb.push_back('{BS, 7, 4, 0, 1});   // miss step: Y still bounces, pulse shown with it
    sb.push_back('{1, 4, 3, 0, 0});
    sb.push_back('{SD * BS + BS, 5, 4, 0, 0});  // re-serve toward P2
    bus.i_Game_Active = 1;
    lx = 4; ly = 3; dt = 0; n1 = 0; n2 = 0;
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      cyc(); dt++;
      if (bus.o_P1_Miss === 1'b1) n1++;
      if (bus.o_P2_Miss === 1'b1) n2++;
      if (int'(bus.o_Ball_X) != lx || int'(bus.o_Ball_Y) != ly) begin
        e = sb.pop_front();
        checks++;
        if (int'(bus.o_Ball_X) == e.x && int'(bus.o_Ball_Y) == e.y && dt == e.dt &&
            int'(bus.o_Speed_Level) == e.lvl && int'(bus.o_P2_Miss) == e.p2m) passed++;
        else $display("FAIL serve_step got (%0d,%0d) dt=%0d lvl=%0d p2m=%0d want (%0d,%0d) dt=%0d lvl=%0d p2m=%0d",
                      bus.o_Ball_X, bus.o_Ball_Y, dt, bus.o_Speed_Level, bus.o_P2_Miss,
                      e.x, e.y, e.dt, e.lvl, e.p2m);
        lx = int'(bus.o_Ball_X); ly = int'(bus.o_Ball_Y); dt = 0;
      end
    end
    checks++;
    if (sb.size() == 0) passed++;
    else begin
      $display("FAIL serve_timeout got %0d steps outstanding want 0", sb.size());
      sb.delete();
    end
    checks++;
    if (n2 == 1) passed++;
    else $display("FAIL p2_miss_width got %0d cycles want 1", n2);
    checks++;
    if (n1 == 0) passed++;
    else $display("FAIL p1_miss_spurious got %0d cycles want 0", n1);
  endtask

  task automatic test_paddle_speed();
    int mx, my, mdx, mdy, per, lvl, hits, nx, ny, p1, dtv;
    int dt, lx, ly, nm;
    bit hit;
    exp_t e;
    bus.i_Game_Active = 0;
    cyc(); cyc();
    bus.i_Paddle_Y_P2 = YW'(3); bus.i_Paddle_Y_P1 = '0; track_p1 = 1;
    // reference trajectory: P2 paddle rows 3..5, P1 paddle follows the ball
    sb.delete();
    mx = 4; my = 3; mdx = 1; mdy = 1; per = BS; lvl = 0; hits = 0;
    for (int t = 0; t < 30; t++) begin
      hit = 0;
      dtv = (t == 0) ? FIRST_DT : per;
      if (mdy == 1 && my == H - 1) begin mdy = -1; ny = my - 1; end
      else if (mdy == -1 && my == 0) begin mdy = 1; ny = 1; end
      else ny = my + mdy;
      if (mdx == 1 && mx == W - 2) hit = (my >= 3 && my <= 3 + PH - 1);
      else if (mdx == -1 && mx == 1) begin
        p1 = (my > H - PH) ? H - PH : my;
        hit = (my >= p1 && my <= p1 + PH - 1);
      end
      if (hit) mdx = -mdx;
      nx = mx + mdx;
      if (hit) begin
        hits++;
        if (hits == HPL) begin
          hits = 0;
          if (lvl < 15) lvl++;
          per = (per >= SMIN + SSTEP) ? per - SSTEP : SMIN;
        end
      end
      sb.push_back('{dtv, nx, ny, lvl, 0});
      mx = nx; my = ny;
    end
    bus.i_Game_Active = 1;
    lx = 4; ly = 3; dt = 0; nm = 0;
    for (int c = 0; c < 600 && sb.size() > 0; c++) begin
      cyc(); dt++;
      if (bus.o_P1_Miss === 1'b1 || bus.o_P2_Miss === 1'b1) nm++;
      if (int'(bus.o_Ball_X) != lx || int'(bus.o_Ball_Y) != ly) begin
        e = sb.pop_front();
        checks++;
        if (int'(bus.o_Ball_X) == e.x && int'(bus.o_Ball_Y) == e.y && dt == e.dt &&
            int'(bus.o_Speed_Level) == e.lvl) passed++;
        else $display("FAIL paddle_step got (%0d,%0d) dt=%0d lvl=%0d want (%0d,%0d) dt=%0d lvl=%0d",
                      bus.o_Ball_X, bus.o_Ball_Y, dt, bus.o_Speed_Level, e.x, e.y, e.dt, e.lvl);
        lx = int'(bus.o_Ball_X); ly = int'(bus.o_Ball_Y); dt = 0;
      end
    end
    checks++;
    if (sb.size() == 0) passed++;
    else begin
      $display("FAIL paddle_timeout got %0d steps outstanding want 0", sb.size());
      sb.delete();
    end
    checks++;
    if (nm == 0) passed++;
    else $display("FAIL paddle_miss got %0d pulse cycles want 0", nm);
  endtask

  task automatic test_game_drop();
    int bad, dt, got_dt;
    cyc();
    bus.i_Game_Active = 0;
    cyc();
    checks++;
    if (int'(bus.o_Ball_X) == 4 && int'(bus.o_Ball_Y) == 3 && bus.o_Speed_Level === 4'd0) passed++;
    else $display("FAIL drop_recentre got (%0d,%0d) lvl=%0d want (4,3) lvl=0",
                  bus.o_Ball_X, bus.o_Ball_Y, bus.o_Speed_Level);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.o_P1_Miss !== 1'b0 || bus.o_P2_Miss !== 1'b0 ||
          int'(bus.o_Ball_X) != 4 || int'(bus.o_Ball_Y) != 3) bad++;
      cyc();
    end
    checks++;
    if (bad == 0) passed++;
    else $display("FAIL drop_hold got %0d bad cycles want 0", bad);
    // counter, period and direction must all be fresh: first step at full serve latency
    bus.i_Game_Active = 1;
    dt = 0; got_dt = -1;
    for (int c = 0; c < 100 && got_dt < 0; c++) begin
      cyc(); dt++;
      if (int'(bus.o_Ball_X) != 4 || int'(bus.o_Ball_Y) != 3) got_dt = dt;
    end
    checks++;
    if (got_dt == FIRST_DT && int'(bus.o_Ball_X) == 5 && int'(bus.o_Ball_Y) == 4 &&
        bus.o_Speed_Level === 4'd0) passed++;
    else $display("FAIL drop_reserve got (%0d,%0d) dt=%0d lvl=%0d want (5,4) dt=%0d lvl=0",
                  bus.o_Ball_X, bus.o_Ball_Y, got_dt, bus.o_Speed_Level, FIRST_DT);
  endtask

  task automatic test_rst_mid_move();
    int dt, got_dt;
    // last step landed on the previous edge; the tick edge is BS clocks later
    repeat (BS - 1) cyc();
    i_Rst = 1;
    cyc();
    checks++;
    if (int'(bus.o_Ball_X) == 4 && int'(bus.o_Ball_Y) == 3) passed++;
    else $display("FAIL rst_tick_pos got (%0d,%0d) want (4,3)", bus.o_Ball_X, bus.o_Ball_Y);
    checks++;
    if (bus.o_Speed_Level === 4'd0 && bus.o_P1_Miss === 1'b0 && bus.o_P2_Miss === 1'b0 &&
        bus.o_Draw_Ball === 1'b0) passed++;
    else $display("FAIL rst_tick_out got lvl=%0d miss=%b%b draw=%b want lvl=0 miss=00 draw=0",
                  bus.o_Speed_Level, bus.o_P1_Miss, bus.o_P2_Miss, bus.o_Draw_Ball);
    i_Rst = 0;
    dt = 0; got_dt = -1;
    for (int c = 0; c < 100 && got_dt < 0; c++) begin
      cyc(); dt++;
      if (int'(bus.o_Ball_X) != 4 || int'(bus.o_Ball_Y) != 3) got_dt = dt;
    end
    checks++;
    if (got_dt == FIRST_DT && int'(bus.o_Ball_X) == 5 && int'(bus.o_Ball_Y) == 4) passed++;
    else $display("FAIL rst_reserve got (%0d,%0d) dt=%0d want (5,4) dt=%0d",
                  bus.o_Ball_X, bus.o_Ball_Y, got_dt, FIRST_DT);
  endtask

  initial begin
    test_reset();
    test_serve_miss();
    test_paddle_speed();
    test_game_drop();
    test_rst_mid_move();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pong_ball_ctrl_v2.md
Name: pong_ball_ctrl_v2

Overview:
Second-generation Pong ball controller. It adds the following to the basic wall-bouncing ball:
- explicit direction state
- paddle collision against both players' paddles
- miss/score pulses
- a serve delay state machine
- progressive speed-up after a number of paddle hits

It sits between the game-state FSM, which supplies i_Game_Active and consumes the miss pulses, and the video pipeline, which supplies the divided column/row counts and consumes o_Draw_Ball.

Parameters:
- c_GAME_WIDTH, 40, playfield columns in game units; P1 paddle column 0, P2 paddle column c_GAME_WIDTH-1
- c_GAME_HEIGHT, 30, playfield rows in game units
- c_PADDLE_HEIGHT, 6, paddle length in rows
- c_BALL_SPEED, 1250000, initial clocks per ball step
- c_BALL_SPEED_MIN, 312500, floor for the step period
- c_SPEED_STEP, 156250, period reduction per speed level
- c_HITS_PER_LEVEL, 4, paddle hits per speed level
- c_SERVE_DELAY, 20, ball steps to hold at centre before a serve

Ports:
- i_Clk, in, 1: system clock
- i_Rst, in, 1: synchronous active-high reset
- i_Game_Active, in, 1: high while a game is running
- i_Col_Count_Div, in, $clog2(c_GAME_WIDTH): current pixel column in game units
- i_Row_Count_Div, in, $clog2(c_GAME_HEIGHT): current pixel row in game units
- i_Paddle_Y_P1, in, $clog2(c_GAME_HEIGHT): top row of the P1 paddle
- i_Paddle_Y_P2, in, $clog2(c_GAME_HEIGHT): top row of the P2 paddle
- o_Draw_Ball, out, 1: registered, high when the pixel is the ball
- o_Ball_X, out, $clog2(c_GAME_WIDTH): ball column
- o_Ball_Y, out, $clog2(c_GAME_HEIGHT): ball row
- o_P1_Miss, out, 1: one-cycle pulse, P1 missed (P2 scores)
- o_P2_Miss, out, 1: one-cycle pulse, P2 missed (P1 scores)
- o_Speed_Level, out, 4: current speed level, saturates at 15

Behaviour:

Reset:
- Reset is synchronous and active-high; it overrides everything, including mid-step.
- Reset values: state IDLE, X=c_GAME_WIDTH/2, Y=c_GAME_HEIGHT/2, dir_x=+1, dir_y=+1.
- Step counter = 0, period = c_BALL_SPEED, hit count = 0, o_Speed_Level = 0.
- Both miss pulses = 0, o_Draw_Ball = 0.

Step tick:
- The step counter runs only in SERVE and MOVE.
- Tick fires when count == period-1; the counter then returns to 0.
- A tick therefore occurs every `period` clocks.
- Position updates are visible the cycle after the tick.

States:
- IDLE: ball held at centre, counter cleared. Exit to SERVE when i_Game_Active=1.
- SERVE: ball held at centre. After c_SERVE_DELAY ticks, go to MOVE.
- MOVE: on each tick apply the X and Y rules below. A miss goes to SCORED.
- SCORED: for one cycle, assert the relevant miss pulse.
  - Recentre the ball; reset period, hit count and level.
  - Set dir_x toward the player who missed; dir_y=+1.
  - Then go to SERVE.
- From any state, i_Game_Active=0 goes to IDLE on the next clock. This recentres the ball and clears the counter, direction, hit count and level. No miss pulse is issued.

Y rule (per MOVE tick):
- If dir_y=+1 and Y==c_GAME_HEIGHT-1: flip to -1 and Y-1.
- If dir_y=-1 and Y==0: flip to +1 and Y+1.
- Otherwise Y+dir_y.

X rule (per MOVE tick):
- At X==c_GAME_WIDTH-2 with dir_x=+1:
  - Hit if i_Paddle_Y_P2 <= Y <= i_Paddle_Y_P2+c_PADDLE_HEIGHT-1, using the current, pre-update Y.
  - On a hit: dir_x=-1 and X-1.
  - On a miss: X=c_GAME_WIDTH-1, then SCORED with o_P2_Miss.
- Mirror case at X==1 with dir_x=-1 against the P1 paddle; a miss sets X=0 and then SCORED with o_P1_Miss.
- Otherwise X+dir_x.
- The paddle range comparison uses a width+1 sum, so there is no wrap.

Simultaneous and boundary rules:
- A corner step applies the Y wall bounce and the X paddle reflect in the same tick.
- On a miss step, Y still updates, giving the final displayed position for the one SCORED cycle.

Speed-up:
- Each paddle hit increments the hit count.
- When the count reaches c_HITS_PER_LEVEL: count=0 and level+1 (saturating).
- Period = max(period-c_SPEED_STEP, c_BALL_SPEED_MIN), computed without underflow.
- The new period applies from the next tick interval.

Draw:
- o_Draw_Ball <= (i_Col_Count_Div==o_Ball_X && i_Row_Count_Div==o_Ball_Y).
- It is registered (one clock of latency) and active in every state.

Test Plan:
Bench parameters: W=8, H=6, PADDLE_HEIGHT=3, BALL_SPEED=4, SPEED_MIN=2, SPEED_STEP=1, HITS_PER_LEVEL=1, SERVE_DELAY=2.

1. Reset, then hold i_Game_Active=0 for 50 clocks -> ball stays at (4,3), no miss pulses, level 0. Drive col=4, row=3 -> o_Draw_Ball=1 one clock later.
2. Raise i_Game_Active with both paddles at Y=0 -> 8 clocks held at (4,3) (serve delay). Then at 4-clock intervals the ball goes (5,4), (6,5), (7,4). o_P2_Miss pulses for exactly 1 cycle, then the ball is back at (4,3) with dir_x=+1.
3. Same as scenario 2, but P2 paddle Y=3 -> from (6,5) the ball goes to (5,4) (paddle reflect plus wall bounce). Level becomes 1 and subsequent steps are 3 clocks apart.
4. Repeated P2 hits (P2 paddle Y=3; P1 paddle tracking the ball) -> level increments on every hit. The period drops 4, 3, 2 and then stays at 2 while the level keeps counting.
5. Drop i_Game_Active mid-MOVE -> next clock the ball is at (4,3), the counter is cleared and level is 0, with no miss pulse.
6. Assert i_Rst mid-MOVE on a tick cycle -> all reset values on the next clock, and the tick's update is discarded.
